// File: rtl/uart_cmd_pkg.sv
// Shared FSM state encoding and protocol byte constants for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM,
    RESP
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;

  function automatic int addr_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: 'W'/'R' frames become single memory requests with a byte response.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK            = 50000000,
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = CLK / 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_finish,
  input  logic [7:0]           rx_data,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 err
);

  localparam int AB    = addr_bytes(ADDR_BITS);
  localparam int CNT_W = ($clog2(AB + 1) < 2) ? 2 : $clog2(AB + 1);
  localparam logic [CNT_W-1:0] AB_LAST = CNT_W'(AB - 1);

  state_t               r_state, w_state_next;
  logic                 r_rx_finish_q;
  logic                 w_strobe;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_mem_req, w_mem_req_next;
  logic                 r_mem_we, w_mem_we_next;
  logic [ADDR_BITS-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_BITS-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [7:0]           r_rd_lo, w_rd_lo_next;
  logic                 r_tx_valid, w_tx_valid_next;
  logic [7:0]           r_tx_data, w_tx_data_next;
  logic                 r_err, w_err_next;
  logic [ADDR_BITS+7:0] w_addr_shift;
  logic                 w_timeout;

  assign w_strobe     = rx_finish & ~r_rx_finish_q;
  assign w_addr_shift = {r_mem_addr, rx_data};

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_in_frame;

  assign w_in_frame = (r_state == ADDR) || (r_state == WDATA);
  // Counter is cleared on every accepted byte, so it measures the silence since the last one.
  assign w_timeout  = w_in_frame && !w_strobe && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_strobe || !w_in_frame) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rx_finish_q <= 1'b0;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_rd_lo       <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rx_finish_q <= rx_finish;
      r_cnt         <= w_cnt_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_we      <= w_mem_we_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_rd_lo       <= w_rd_lo_next;
      r_tx_valid    <= w_tx_valid_next;
      r_tx_data     <= w_tx_data_next;
      r_err         <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_rd_lo_next     = r_rd_lo;
    w_tx_valid_next  = r_tx_valid;
    w_tx_data_next   = r_tx_data;
    w_err_next       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_strobe) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            w_mem_we_next = (rx_data == OP_WRITE);
            w_cnt_next    = '0;
            w_state_next  = ADDR;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ADDR: begin
        if (w_strobe) begin
          w_mem_addr_next = w_addr_shift[ADDR_BITS-1:0];
          if (r_cnt == AB_LAST) begin
            w_cnt_next = '0;
            if (r_mem_we) begin
              w_state_next = WDATA;
            end else begin
              w_state_next   = MEM;
              w_mem_req_next = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      WDATA: begin
        if (w_strobe) begin
          w_mem_wdata_next = {r_mem_wdata[7:0], rx_data};
          if (r_cnt == CNT_W'(1)) begin
            w_cnt_next     = '0;
            w_state_next   = MEM;
            w_mem_req_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      MEM: begin
        w_err_next = w_strobe;
        if (mem_ack) begin
          w_mem_req_next  = 1'b0;
          w_tx_valid_next = 1'b1;
          w_cnt_next      = '0;
          w_state_next    = RESP;
          if (r_mem_we) begin
            w_tx_data_next = RSP_OK;
          end else begin
            w_tx_data_next = mem_rdata[15:8];
            w_rd_lo_next   = mem_rdata[7:0];
          end
        end
      end
      RESP: begin
        w_err_next = w_strobe;
        // r_cnt marks whether the low read byte has already been queued.
        if (tx_ready) begin
          if (!r_mem_we && r_cnt == '0) begin
            w_tx_data_next = r_rd_lo;
            w_cnt_next     = CNT_W'(1);
          end else begin
            w_tx_valid_next = 1'b0;
            w_cnt_next      = '0;
            w_state_next    = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_timeout) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_err_next   = 1'b1;
    end
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLK, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter ADDR_BITS, default 24, memory address width; address byte count AB = ceil(ADDR_BITS/8).
REQ-003 SHALL have parameter DATA_BITS, default 16, memory word width, fixed at 16 (two data bytes).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default CLK/100, inter-byte timeout in clk cycles.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_finish  in  1  receiver byte-done level; may stay high for many cycles.
- rx_data  in  8  received byte, stable while rx_finish is high.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte.
- tx_ready  in  1  transmitter accepts the byte when tx_valid & tx_ready.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_BITS  word address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  16  read data.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle pulse on a protocol error.

Function
REQ-006 SHALL derive byte strobe = rx_finish & ~rx_finish_q (registered copy), sampling rx_data on the strobe cycle; exactly one strobe per byte.
REQ-007 SHALL use frame format: opcode byte, then AB address bytes MSB first; write opcode 0x57 ('W') is followed by 2 data bytes MSB first; read opcode 0x52 ('R') has no data bytes.
REQ-008 SHALL use states IDLE, ADDR, WDATA, MEM, RESP.
REQ-009 IDLE: on strobe with 0x57 or 0x52 SHALL latch mem_we and go to ADDR; any other byte SHALL pulse err and remain in IDLE.
REQ-010 ADDR: SHALL shift each byte into mem_addr, keeping only the low ADDR_BITS bits; after byte AB SHALL go to WDATA if writing, otherwise to MEM.
REQ-011 WDATA: after 2 bytes SHALL go to MEM.
REQ-012 MEM: mem_req SHALL assert in the cycle after the final frame byte's strobe and hold until the mem_ack cycle; it SHALL drop the next cycle; mem_we, mem_addr and mem_wdata SHALL stay stable while mem_req is high.
REQ-013 On a read ack SHALL capture mem_rdata; on any ack SHALL go to RESP.
REQ-014 RESP: tx_valid SHALL assert the cycle after the ack and hold, with tx_data stable, until tx_ready. Write response is one byte 0x4B ('K'). Read response is rdata[15:8] then rdata[7:0]. After the last transfer SHALL return to IDLE.
REQ-015 Strobes arriving in MEM or RESP SHALL be dropped with an err pulse; the state SHALL be unaffected.
REQ-016 mem_ack outside MEM SHALL be ignored.

Reset
REQ-017 On rst_n low SHALL immediately set: state IDLE; tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err, rx_finish_q, and all counters to 0. This applies mid-frame and mid-request alike.
REQ-018 rx_finish_q SHALL reset to 0, so a rx_finish already high at release yields one strobe.

Configuration
REQ-019 With UART_CMD_TIMEOUT_EN defined, SHALL count cycles since the last strobe in ADDR/WDATA; reaching TIMEOUT_CYCLES SHALL pulse err and return to IDLE, discarding the partial frame.
REQ-020 Without UART_CMD_TIMEOUT_EN, no timeout counter SHALL exist and partial frames SHALL wait indefinitely.

Structure
REQ-021 Package uart_cmd_pkg SHALL hold the state enum and opcode/response constants (OP_WRITE 8'h57, OP_READ 8'h52, RSP_OK 8'h4B).
REQ-022 SHALL be a single module with no sub-module; receiver and transmitter instances live outside the block.

Verification
REQ-023 Bytes 57 01 23 45 BE EF, mem_ack 3 cycles after req -> one request, we=1, addr=0x012345, wdata=0xBEEF; tx 0x4B; busy low afterwards.
REQ-024 Bytes 52 00 00 10, ack with rdata=0xCAFE, tx_ready low 5 cycles -> tx_valid holds 0xCA; then 0xCA, 0xFE in order.
REQ-025 rx_finish held high 400 cycles per byte -> exactly one strobe per byte; frame decodes correctly.
REQ-026 Byte 0x41 in IDLE -> err pulse, no mem_req; a following valid frame completes normally.
REQ-027 With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: bytes 57 01 then silence -> err at cycle 100, IDLE, no mem_req. Without the macro: still busy at 1000 cycles.
REQ-028 rst_n low while mem_req is high -> mem_req, busy, tx_valid 0 immediately; next frame after release completes normally.
